history_copy_ctrl: RTL and testbench

HISTORY_COPY_CTRL -- requirements
Module: history_copy_ctrl

---
 rtl/history_copy_ctrl.sv | 130 +++++++++++++
 tb/tb_history_copy_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/history_copy_ctrl.sv
// LZ-style history copy controller: turns literal/copy tokens into a 1 byte/cycle
// output stream, reading far matches from history RAM and short ones from a 4-byte window.
module history_copy_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        tok_valid,
    input  logic        tok_is_copy,
    input  logic [7:0]  tok_literal,
    input  logic [10:0] tok_offset,
    input  logic [11:0] tok_length,
    output logic        tok_ready,
    output logic [10:0] hist_raddr,
    output logic        hist_rd,
    input  logic [7:0]  hist_rdata,
    output logic [7:0]  decode_result,
    output logic        result_valid,
    output logic        tok_error
);

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_DRAIN} state_t;

    localparam int HIST_N = 4;

    state_t                   r_state, w_state_nxt;
    logic [10:0]              r_wptr;
    logic [10:0]              r_src;
    logic [11:0]              r_rem;
    logic [10:0]              r_off;
    logic [HIST_N-1:0][7:0]   r_shift;
    logic [7:0]               r_lit;
    logic                     r_valid;
    logic                     r_from_ram;
    logic                     r_err;
    logic                     r_rdy_en;

    logic                     w_accept;
    logic                     w_legal;
    logic                     w_bypass;
    logic [10:0]              w_wptr_nxt;
    logic [HIST_N-1:0][7:0]   w_hist;
    logic [1:0]               w_byp_idx;
    logic [7:0]               w_byp_byte;

    assign tok_ready     = (r_state == S_IDLE) && r_rdy_en;
    assign w_accept      = tok_valid && tok_ready;
    assign w_legal       = (tok_offset != 11'd0) && (tok_length != 12'd0);
    assign w_bypass      = (r_off < 11'd5);

    // Address the next emitted byte will land on, counting a byte still in flight.
    assign w_wptr_nxt    = r_wptr + {10'd0, r_valid};

    assign decode_result = r_from_ram ? hist_rdata : r_lit;
    assign result_valid  = r_valid;
    assign tok_error     = r_err;

    // Window seen by the bypass path includes the byte on the output this cycle.
    assign w_hist        = r_valid ? {r_shift[HIST_N-2:0], decode_result} : r_shift;
    assign w_byp_idx     = r_off[1:0] - 2'd1;
    assign w_byp_byte    = w_hist[w_byp_idx];

    assign hist_rd       = (r_state == S_COPY) && !w_bypass;
    assign hist_raddr    = r_src;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && tok_is_copy && w_legal) w_state_nxt = S_COPY;
            S_COPY:  if (r_rem == 12'd1) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_src      <= '0;
            r_rem      <= '0;
            r_off      <= '0;
            r_shift    <= '0;
            r_lit      <= '0;
            r_valid    <= 1'b0;
            r_from_ram <= 1'b0;
            r_err      <= 1'b0;
            r_rdy_en   <= 1'b0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_valid    <= 1'b0;
            r_from_ram <= 1'b0;
            r_err      <= 1'b0;
            if (r_valid) begin
                r_wptr  <= r_wptr + 11'd1;
                r_shift <= {r_shift[HIST_N-2:0], decode_result};
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!tok_is_copy) begin
                            r_lit   <= tok_literal;
                            r_valid <= 1'b1;
                        end else if (w_legal) begin
                            r_off <= tok_offset;
                            r_rem <= tok_length;
                            r_src <= w_wptr_nxt - tok_offset;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_COPY: begin
                    r_rem   <= r_rem - 12'd1;
                    r_valid <= 1'b1;
                    if (w_bypass) begin
                        r_lit <= w_byp_byte;
                    end else begin
                        r_src      <= r_src + 11'd1;
                        r_from_ram <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_history_copy_ctrl.sv
// Directed bench for history_copy_ctrl with a behavioural history RAM and output-stage mirror.
module tb_history_copy_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tok_valid = 1'b0;
    logic        tok_is_copy = 1'b0;
    logic [7:0]  tok_literal = '0;
    logic [10:0] tok_offset = '0;
    logic [11:0] tok_length = '0;
    logic        tok_ready;
    logic [10:0] hist_raddr;
    logic        hist_rd;
    logic [7:0]  hist_rdata = '0;
    logic [7:0]  decode_result;
    logic        result_valid;
    logic        tok_error;

    history_copy_ctrl dut (
        .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_is_copy(tok_is_copy),
        .tok_literal(tok_literal), .tok_offset(tok_offset), .tok_length(tok_length),
        .tok_ready(tok_ready), .hist_raddr(hist_raddr), .hist_rd(hist_rd),
        .hist_rdata(hist_rdata), .decode_result(decode_result),
        .result_valid(result_valid), .tok_error(tok_error)
    );

    always #5 clk = ~clk;

    // External history RAM written by the output stage.
    logic [7:0]  mem [0:2047];
    logic [10:0] m_wptr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_wptr <= '0;
        else if (result_valid) m_wptr <= m_wptr + 11'd1;
    end
    always @(posedge clk) begin
        if (rst && result_valid) mem[m_wptr] <= decode_result;
        if (hist_rd) hist_rdata <= mem[hist_raddr];
    end

    int        cyc = 0;
    logic [7:0]  outq[$];
    int          outc[$];
    logic [10:0] addrq[$];
    int          addrc[$];
    int          n_errp = 0;
    int          n_low = 0;

    always @(negedge clk) begin
        cyc++;
        if (result_valid) begin outq.push_back(decode_result); outc.push_back(cyc); end
        if (hist_rd) begin addrq.push_back(hist_raddr); addrc.push_back(cyc); end
        if (tok_error) n_errp++;
        if (!tok_ready) n_low++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        outq.delete(); outc.delete(); addrq.delete(); addrc.delete();
        n_errp = 0; n_low = 0;
    endtask

    task automatic send(input bit c, input logic [7:0] l, input logic [10:0] o, input logic [11:0] n);
        int k;
        k = 0;
        @(negedge clk);
        while (!tok_ready && k < 100) begin @(negedge clk); k++; end
        if (!tok_ready) chk("send_ready_timeout", 0, 1);
        tok_valid = 1'b1; tok_is_copy = c; tok_literal = l; tok_offset = o; tok_length = n;
        @(posedge clk);
        #1 tok_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (tok_ready) break;
        end
        if (!tok_ready) chk("idle_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [7:0] exp4 [4];
    int vcnt;

    initial begin
        // Reset state
        #12;
        chk("rst_valid", result_valid, 0);
        chk("rst_data", decode_result, 0);
        chk("rst_hist_rd", hist_rd, 0);
        chk("rst_raddr", hist_raddr, 0);
        chk("rst_err", tok_error, 0);
        chk("rst_ready", tok_ready, 0);
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", tok_ready, 1);

        // Three back-to-back literals then seven more, filling addresses 0..9
        clr();
        send(0, 8'h41, 0, 0); send(0, 8'h42, 0, 0); send(0, 8'h43, 0, 0);
        wait_idle();
        chk("lit_cnt", outq.size(), 3);
        if (outq.size() == 3) begin
            chk("lit0", outq[0], 8'h41);
            chk("lit1", outq[1], 8'h42);
            chk("lit2", outq[2], 8'h43);
            chk("lit_consec", outc[2] - outc[0], 2);
        end
        for (int i = 0; i < 7; i++) send(0, 8'h44 + 8'(i), 0, 0);
        wait_idle();

        // Far copy from RAM: wptr=10, offset 8
        clr();
        send(1, 0, 11'd8, 12'd3);
        wait_idle();
        chk("far_rd_cnt", addrq.size(), 3);
        chk("far_out_cnt", outq.size(), 3);
        if (addrq.size() == 3 && outq.size() == 3) begin
            chk("far_a0", addrq[0], 2);
            chk("far_a1", addrq[1], 3);
            chk("far_a2", addrq[2], 4);
            chk("far_a_consec", addrc[2] - addrc[0], 2);
            chk("far_lat", outc[0] - addrc[0], 1);
            chk("far_d0", outq[0], 8'h43);
            chk("far_d1", outq[1], 8'h44);
            chk("far_d2", outq[2], 8'h45);
        end

        // Overlapping short copy via the 4-byte window
        send(0, 8'h61, 0, 0); send(0, 8'h62, 0, 0);
        wait_idle();
        clr();
        send(1, 0, 11'd2, 12'd5);
        wait_idle();
        exp4[0] = 8'h61; exp4[1] = 8'h62; exp4[2] = 8'h61; exp4[3] = 8'h62;
        chk("byp_cnt", outq.size(), 5);
        chk("byp_no_rd", addrq.size(), 0);
        chk("byp_ready_low", n_low, 6);
        if (outq.size() == 5) begin
            for (int i = 0; i < 4; i++) chk($sformatf("byp_d%0d", i), outq[i], exp4[i]);
            chk("byp_d4", outq[4], 8'h61);
            chk("byp_consec", outc[4] - outc[0], 4);
        end

        // Illegal copies
        clr();
        send(1, 0, 11'd0, 12'd3);
        wait_idle();
        chk("ill_off_err", n_errp, 1);
        chk("ill_off_out", outq.size(), 0);
        chk("ill_off_ready", n_low, 0);
        clr();
        send(1, 0, 11'd5, 12'd0);
        wait_idle();
        chk("ill_len_err", n_errp, 1);
        chk("ill_len_out", outq.size(), 0);

        // Advance wptr 20 -> 2046; byte at address a is a[7:0]
        for (int k = 0; k < 2026; k++) send(0, 8'(20 + k), 0, 0);
        wait_idle();
        clr();
        send(1, 0, 11'd6, 12'd4);
        wait_idle();
        chk("wrap1_cnt", addrq.size(), 4);
        if (addrq.size() == 4 && outq.size() == 4) begin
            chk("wrap1_a0", addrq[0], 2040);
            chk("wrap1_a3", addrq[3], 2043);
            chk("wrap1_d0", outq[0], 8'hF8);
            chk("wrap1_d3", outq[3], 8'hFB);
        end
        send(0, 8'h02, 0, 0);
        wait_idle();
        clr();
        send(1, 0, 11'd6, 12'd4);
        wait_idle();
        chk("wrap2_cnt", addrq.size(), 4);
        if (addrq.size() == 4 && outq.size() == 4) begin
            chk("wrap2_a0", addrq[0], 2045);
            chk("wrap2_a1", addrq[1], 2046);
            chk("wrap2_a2", addrq[2], 2047);
            chk("wrap2_a3", addrq[3], 0);
            chk("wrap2_nogap", addrc[3] - addrc[0], 3);
            chk("wrap2_d0", outq[0], 8'hFD);
            chk("wrap2_d1", outq[1], 8'hF8);
            chk("wrap2_d3", outq[3], 8'hFA);
        end

        // Reset during the third byte of a length-10 copy
        send(1, 0, 11'd5, 12'd10);
        vcnt = 0;
        for (int i = 0; i < 50 && vcnt < 3; i++) begin
            @(posedge clk); #1;
            if (result_valid) vcnt++;
        end
        chk("abort_reached", vcnt, 3);
        rst = 1'b0;
        #1;
        chk("abort_valid", result_valid, 0);
        chk("abort_rd", hist_rd, 0);
        chk("abort_data", decode_result, 0);
        chk("abort_raddr", hist_raddr, 0);
        chk("abort_ready", tok_ready, 0);
        clr();
        repeat (4) @(posedge clk);
        @(negedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("abort_no_out", outq.size(), 0);
        chk("abort_no_rd", addrq.size(), 0);
        clr();
        send(0, 8'h55, 0, 0);
        for (int k = 1; k <= 4; k++) send(0, 8'(k), 0, 0);
        wait_idle();
        chk("post_lit", (outq.size() > 0) ? outq[0] : 8'h00, 8'h55);
        clr();
        send(1, 0, 11'd5, 12'd1);
        wait_idle();
        chk("post_raddr", (addrq.size() > 0) ? addrq[0] : 11'h7FF, 0);
        chk("post_byte", (outq.size() > 0) ? outq[0] : 8'h00, 8'h55);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
